// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, funct3/funct7 encodings and
// the immediate-format selection used by the decode stage.
package rv32i_pkg;

    // Major opcodes (ir[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // BRANCH funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // LOAD funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // STORE funct3
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // SYSTEM funct3: 000 is the privileged group, 100 is unassigned
    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_RSVD   = 3'b100;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // OP-IMM shift funct3
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SRXI  = 3'b101;
    // OP funct3 allowed with the alternate funct7 (SUB, SRA)
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SRLSRA = 3'b101;

    // funct7
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    // Immediate format implied by the major opcode; OP, MISC-MEM and
    // unknown opcodes carry no immediate.
    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        imm_fmt_e f;
        case (opc)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: f = FMT_I;
            OPC_STORE:                                  f = FMT_S;
            OPC_BRANCH:                                 f = FMT_B;
            OPC_LUI, OPC_AUIPC:                         f = FMT_U;
            OPC_JAL:                                    f = FMT_J;
            default:                                    f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rv32i_id_stage_if.sv
// Decode-stage bundle: instruction word in, decoded fields and flags out.
interface rv32i_id_stage_if;
    logic [31:0] ir;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] csr_addr;
    logic [31:0] imm;
    logic        wr_reg_n;
    logic        wr_csr_n;
    logic        illegal_ir;

    // Pipeline side supplying the instruction and consuming the decode
    modport master (
        output ir,
        input  rs1, rs2, rd, opcode, funct3, funct7, csr_addr, imm,
               wr_reg_n, wr_csr_n, illegal_ir
    );

    // Decoder side
    modport slave (
        input  ir,
        output rs1, rs2, rd, opcode, funct3, funct7, csr_addr, imm,
               wr_reg_n, wr_csr_n, illegal_ir
    );
endinterface

// File: rtl/rv32i_id_stage_imm_gen.sv
// Immediate generator: reassembles and sign-extends the immediate field
// according to the instruction format implied by the opcode.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm
);

    imm_fmt_e fmt;

    assign fmt = imm_fmt(ir[6:0]);

    // Format mux; ir[31] is the sign bit for every signed format
    always_comb begin
        imm = 32'h0;
        case (fmt)
            FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
            FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_U:   imm = {ir[31:12], 12'h000};
            FMT_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv32i_id_stage.sv
// RV32I instruction decode: raw field extraction, immediate generation,
// active-low write enables and the illegal-instruction flag. Purely
// combinational; clk/rst are accepted for pipeline uniformity only.
module rv32i_id_stage
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    rv32i_id_stage_if.slave id
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       csr_op;
    logic       rd_nz;

    // No state here: clk and rst are deliberately left without effect
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign opc = id.ir[6:0];
    assign f3  = id.ir[14:12];
    assign f7  = id.ir[31:25];

    // Raw fields are passed through regardless of format or legality
    assign id.rs1      = id.ir[19:15];
    assign id.rs2      = id.ir[24:20];
    assign id.rd       = id.ir[11:7];
    assign id.opcode   = opc;
    assign id.funct3   = f3;
    assign id.funct7   = f7;
    assign id.csr_addr = id.ir[31:20];

    imm_gen u_imm_gen (
        .ir  (id.ir),
        .imm (id.imm)
    );

    // Any non-privileged SYSTEM encoding is treated as a CSR access, even
    // the reserved funct3=100; the trap path catches it via illegal_ir.
    assign csr_op = (opc == OPC_SYSTEM) && (f3 != F3_PRIV);
    assign rd_nz  = (id.ir[11:7] != 5'd0);

    assign id.wr_csr_n = ~csr_op;

    // Register-file write enable: opcodes that produce a result in rd
    always_comb begin
        id.wr_reg_n = 1'b1;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP_IMM, OPC_OP: id.wr_reg_n = ~rd_nz;
            OPC_SYSTEM:                   id.wr_reg_n = ~(rd_nz && csr_op);
            default:                      id.wr_reg_n = 1'b1;
        endcase
    end

    // Legality check per opcode; unknown opcodes (incl. ir[1:0] != 11) trap
    always_comb begin
        id.illegal_ir = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM: id.illegal_ir = 1'b0;
            OPC_JALR:   id.illegal_ir = (f3 != 3'b000);
            OPC_BRANCH: id.illegal_ir = (f3 == 3'b010) || (f3 == 3'b011);
            OPC_LOAD:   id.illegal_ir = (f3 == 3'b011) || (f3 == 3'b110) ||
                                        (f3 == 3'b111);
            OPC_STORE:  id.illegal_ir = (f3 > F3_SW);
            OPC_OP_IMM: begin
                if (f3 == F3_SLLI)
                    id.illegal_ir = (f7 != F7_ZERO);
                else if (f3 == F3_SRXI)
                    id.illegal_ir = (f7 != F7_ZERO) && (f7 != F7_ALT);
                else
                    id.illegal_ir = 1'b0;
            end
            OPC_OP: begin
                if (f7 == F7_ALT)
                    id.illegal_ir = (f3 != F3_ADDSUB) && (f3 != F3_SRLSRA);
                else
                    id.illegal_ir = (f7 != F7_ZERO);
            end
            OPC_SYSTEM: id.illegal_ir = (f3 == F3_PRIV) || (f3 == F3_RSVD);
            default:    id.illegal_ir = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_rv32i_id_stage.sv
// Bench for rv32i_id_stage: directed vectors with literal expectations plus
// an every-cycle comparison against a behavioural decode model.
module tb_rv32i_id_stage;

    logic clk = 1'b0;
    logic rst;
    bit   live = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rv32i_id_stage_if id_if();

    rv32i_id_stage dut (
        .clk (clk),
        .rst (rst),
        .id  (id_if)
    );

    typedef struct {
        logic [31:0] imm;
        logic        wrr_n;
        logic        wrc_n;
        logic        ill;
    } exp_t;

    // Behavioural decode: immediates by signed-shift arithmetic, legality by
    // per-opcode set membership.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   s;
        int   v;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       writes;
        s  = $signed(w);
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        case (op)
            7'h67, 7'h03, 7'h13, 7'h73: v = s >>> 20;
            7'h23: v = ((s >>> 25) <<< 5) | int'(w[11:7]);
            7'h63: v = ((s >>> 31) <<< 12) | (int'(w[7]) <<< 11) |
                       (int'(w[30:25]) <<< 5) | (int'(w[11:8]) <<< 1);
            7'h37, 7'h17: v = s & 32'hFFFF_F000;
            7'h6F: v = ((s >>> 31) <<< 20) | (int'(w[19:12]) <<< 12) |
                       (int'(w[20]) <<< 11) | (int'(w[30:21]) <<< 1);
            default: v = 0;
        endcase
        e.imm = v;
        case (op)
            7'h37, 7'h17, 7'h6F, 7'h0F: e.ill = 1'b0;
            7'h67: e.ill = (f3 != 0);
            7'h63: e.ill = f3 inside {3'd2, 3'd3};
            7'h03: e.ill = f3 inside {3'd3, 3'd6, 3'd7};
            7'h23: e.ill = (f3 >= 3);
            7'h13: e.ill = (f3 == 1) ? (f7 != 0) :
                           (f3 == 5) ? !(f7 inside {7'd0, 7'd32}) : 1'b0;
            7'h33: e.ill = !((f7 == 0) || (f7 == 32 && (f3 inside {3'd0, 3'd5})));
            7'h73: e.ill = f3 inside {3'd0, 3'd4};
            default: e.ill = 1'b1;
        endcase
        writes  = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) ||
                  (op == 7'h73 && f3 != 0);
        e.wrr_n = !(writes && w[11:7] != 0);
        e.wrc_n = !(op == 7'h73 && f3 != 0);
        return e;
    endfunction

    // Every-cycle comparison of all outputs against the model and raw slices
    always @(negedge clk) begin
        if (live) begin
            exp_t e;
            logic [31:0] w;
            w = id_if.ir;
            e = model(w);
            checks++;
            if (id_if.imm !== e.imm || id_if.wr_reg_n !== e.wrr_n ||
                id_if.wr_csr_n !== e.wrc_n || id_if.illegal_ir !== e.ill ||
                id_if.rs1 !== w[19:15] || id_if.rs2 !== w[24:20] ||
                id_if.rd !== w[11:7] || id_if.opcode !== w[6:0] ||
                id_if.funct3 !== w[14:12] || id_if.funct7 !== w[31:25] ||
                id_if.csr_addr !== w[31:20]) begin
                errors++;
                $display("FAIL model ir=%08h got imm=%08h wrr=%b wrc=%b ill=%b rs1=%0d rs2=%0d rd=%0d csr=%03h want imm=%08h wrr=%b wrc=%b ill=%b",
                         w, id_if.imm, id_if.wr_reg_n, id_if.wr_csr_n, id_if.illegal_ir,
                         id_if.rs1, id_if.rs2, id_if.rd, id_if.csr_addr,
                         e.imm, e.wrr_n, e.wrc_n, e.ill);
            end
        end
    end

    task automatic apply(input logic [31:0] w);
        @(posedge clk);
        #1 id_if.ir = w;
        #1;
    endtask

    // Directed vector: DUT against hand-computed literals, and model pinned
    task automatic vec(input string name, input logic [31:0] w, input logic [31:0] imm,
                       input logic wrr, input logic wrc, input logic ill);
        exp_t m;
        apply(w);
        checks++;
        if (id_if.imm !== imm || id_if.wr_reg_n !== wrr ||
            id_if.wr_csr_n !== wrc || id_if.illegal_ir !== ill) begin
            errors++;
            $display("FAIL %s ir=%08h got imm=%08h wrr=%b wrc=%b ill=%b want imm=%08h wrr=%b wrc=%b ill=%b",
                     name, w, id_if.imm, id_if.wr_reg_n, id_if.wr_csr_n,
                     id_if.illegal_ir, imm, wrr, wrc, ill);
        end
        m = model(w);
        checks++;
        if (m.imm !== imm || m.wrr_n !== wrr || m.wrc_n !== wrc || m.ill !== ill) begin
            errors++;
            $display("FAIL pin_%s model imm=%08h wrr=%b wrc=%b ill=%b want imm=%08h wrr=%b wrc=%b ill=%b",
                     name, m.imm, m.wrr_n, m.wrc_n, m.ill, imm, wrr, wrc, ill);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h", name, got, want);
        end
    endtask

    logic [6:0] known_ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                   7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    initial begin
        rst      = 1'b1;
        id_if.ir = 32'h0000_0013;
        #1 live  = 1'b1;

        // Reset holds a NOP in IF/ID; outputs follow it
        vec("reset_nop", 32'h0000_0013, 32'h0, 1'b1, 1'b1, 1'b0);
        vec("reset_addi", 32'h8010_8193, 32'hFFFF_F801, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        rst = 1'b0;

        vec("jal",       32'h0020_01EF, 32'h2,         1'b0, 1'b1, 1'b0);
        vec("jal_rd0",   32'h0020_006F, 32'h2,         1'b1, 1'b1, 1'b0);
        vec("addi",      32'h8010_8193, 32'hFFFF_F801, 1'b0, 1'b1, 1'b0);
        chk("addi_rs1", {27'd0, id_if.rs1}, 32'd1);
        chk("addi_rd",  {27'd0, id_if.rd},  32'd3);
        vec("beq",       32'h0020_8163, 32'h2,         1'b1, 1'b1, 1'b0);
        vec("beq_f3_2",  32'h0020_A163, 32'h2,         1'b1, 1'b1, 1'b1);
        vec("sb",        32'h0020_8123, 32'h2,         1'b1, 1'b1, 1'b0);
        for (int f = 3; f <= 7; f++)
            vec($sformatf("store_f3_%0d", f), 32'h0020_8123 | (f << 12),
                32'h2, 1'b1, 1'b1, 1'b1);
        vec("lb",        32'h0000_8183, 32'h0,         1'b0, 1'b1, 1'b0);
        vec("load_f3_3", 32'h0000_B183, 32'h0,         1'b0, 1'b1, 1'b1);
        vec("load_f3_6", 32'h0000_E183, 32'h0,         1'b0, 1'b1, 1'b1);
        vec("load_f3_7", 32'h0000_F183, 32'h0,         1'b0, 1'b1, 1'b1);
        vec("csrrw",     32'h3000_9173, 32'h300,       1'b0, 1'b0, 1'b0);
        chk("csrrw_addr", {20'd0, id_if.csr_addr}, 32'h300);
        vec("csr_f3_4",  32'h3000_C173, 32'h300,       1'b0, 1'b0, 1'b1);
        vec("ecall",     32'h0000_0073, 32'h0,         1'b1, 1'b1, 1'b1);
        vec("jalr_f3_1", 32'h0000_10E7, 32'h0,         1'b0, 1'b1, 1'b1);
        vec("jalr",      32'h0000_80E7, 32'h0,         1'b0, 1'b1, 1'b0);
        vec("lui",       32'h1234_50B7, 32'h1234_5000, 1'b0, 1'b1, 1'b0);
        vec("auipc_neg", 32'hFFFF_F297, 32'hFFFF_F000, 1'b0, 1'b1, 1'b0);
        vec("sub",       32'h4020_80B3, 32'h0,         1'b0, 1'b1, 1'b0);
        vec("op_alt_f1", 32'h4020_90B3, 32'h0,         1'b0, 1'b1, 1'b1);
        vec("op_f7_1",   32'h0220_80B3, 32'h0,         1'b0, 1'b1, 1'b1);
        vec("srai",      32'h4010_D093, 32'h401,       1'b0, 1'b1, 1'b0);
        vec("slli_alt",  32'h4010_9093, 32'h401,       1'b0, 1'b1, 1'b1);
        vec("fence",     32'h0FF0_000F, 32'h0,         1'b1, 1'b1, 1'b0);
        vec("low_bits",  32'h0000_0010, 32'h0,         1'b1, 1'b1, 1'b1);
        vec("sw_neg",    32'hFE20_AE23, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        vec("jal_neg",   32'hFFFF_F06F, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
        vec("beq_neg",   32'hFE00_0FE3, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);

        // Reset asserted mid-stream must not change the decode
        rst = 1'b1;
        apply(32'h3000_9173);
        apply(32'hFFFF_F06F);
        rst = 1'b0;

        // Random words, half of them forced onto a known opcode
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            w = $urandom;
            if (i[0])
                w[6:0] = known_ops[$urandom_range(0, 10)];
            apply(w);
        end

        @(posedge clk);
        live = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_id_stage.md
# rv32i_id_stage

Instruction-decode stage of the RV32I five-stage pipeline. Takes the 32-bit instruction word from the IF/ID register and combinationally produces register indices, raw opcode/funct fields, CSR address, a sign-extended immediate, active-low register-file and CSR write enables, and an illegal-instruction flag. The flag feeds the trap logic. Downstream stages gate writes with `illegal_ir`; this block does not.

## Interface
- No parameters.
- `clk`: input, 1 bit. Pipeline clock. Not used by the decode logic.
- `rst`: input, 1 bit. Synchronous, active-high reset. Not used by the decode logic.
- `ir`: input, 32 bits. Instruction word.
- `rs1`: output, 5 bits. `ir[19:15]`, always passed through raw.
- `rs2`: output, 5 bits. `ir[24:20]`, always raw.
- `rd`: output, 5 bits. `ir[11:7]`, always raw.
- `opcode`: output, 7 bits. `ir[6:0]`.
- `funct3`: output, 3 bits. `ir[14:12]`.
- `funct7`: output, 7 bits. `ir[31:25]`.
- `csr_addr`: output, 12 bits. `ir[31:20]`.
- `imm`: output, 32 bits. Immediate, decoded by instruction format.
- `wr_reg_n`: output, 1 bit. 0 means write `rd` in the register file.
- `wr_csr_n`: output, 1 bit. 0 means write the CSR at `csr_addr`.
- `illegal_ir`: output, 1 bit. 1 means the instruction is unsupported or malformed.

## Operation
Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, MISC-MEM 0001111, SYSTEM 1110011.

- **imm**, by format:
  - I (JALR, LOAD, OP-IMM, SYSTEM): sext(`ir[31:20]`).
  - S: sext({`ir[31:25]`, `ir[11:7]`}).
  - B: sext({`ir[31]`, `ir[7]`, `ir[30:25]`, `ir[11:8]`, 0}).
  - U: {`ir[31:12]`, 12'b0}.
  - J: sext({`ir[31]`, `ir[19:12]`, `ir[20]`, `ir[30:21]`, 0}).
  - OP, MISC-MEM and unknown opcodes: 0.
- **wr_reg_n = 0** iff `rd` != 0 and one of:
  - opcode is LUI, AUIPC, JAL, JALR, LOAD, OP-IMM or OP;
  - opcode is SYSTEM with `funct3` != 000.
  - Otherwise 1.
  - Independent of `illegal_ir`.
- **wr_csr_n = 0** iff opcode is SYSTEM and `funct3` != 000. Independent of `illegal_ir`.
- **illegal_ir = 1** when any of the following holds:
  - unknown opcode, including `ir[1:0]` != 11;
  - JALR with `funct3` != 000;
  - BRANCH with `funct3` in {010, 011};
  - LOAD with `funct3` in {011, 110, 111};
  - STORE with `funct3` >= 011;
  - OP-IMM with `funct3` = 001 and `funct7` != 0000000;
  - OP-IMM with `funct3` = 101 and `funct7` not in {0000000, 0100000};
  - OP with `funct7` = 0100000 and `funct3` not in {000, 101};
  - OP with `funct7` not in {0000000, 0100000};
  - SYSTEM with `funct3` in {000, 100}. ECALL, EBREAK and xRET are all flagged illegal.
- MISC-MEM (FENCE) is legal and behaves as a NOP: `wr_reg_n` = 1, `wr_csr_n` = 1.

## Timing
- Purely combinational. Every output follows `ir` with zero cycles of latency.
- No internal state. `clk` and `rst` do not affect any output.
- Outputs during reset follow `ir`. The IF/ID register supplies a NOP (0x00000013) while reset is asserted.

## Structure
- Shared package `rv32i_pkg` holds:
  - opcode localparams;
  - funct3 constants for BRANCH, LOAD, STORE and CSR;
  - funct7 constants 0000000 and 0100000.
- One natural sub-module, `imm_gen`: input `ir`, output the 32-bit `imm`, with format selected by opcode.

## Test plan
- JAL `ir` = 0x0020_01EF (imm field 1, `rd` = 3):
  - expect `imm` = 2, `wr_reg_n` = 0, `illegal_ir` = 0;
  - with `rd` = 0 (`ir` = 0x0020_006F), expect `wr_reg_n` = 1.
- ADDI `ir` = 0x8010_8193 (x3, x1, 0x801): expect `imm` = 0xFFFF_F801, `rs1` = 1, `rd` = 3, `wr_reg_n` = 0, `illegal_ir` = 0.
- BEQ x1, x2, +2 (`ir` = 0x0020_8163): expect `imm` = 2, `wr_reg_n` = 1, `illegal_ir` = 0. Change `funct3` to 010, expect `illegal_ir` = 1.
- Store and load legality:
  - SB x2, 2(x1) gives `imm` = 2, `illegal_ir` = 0.
  - Store `funct3` sweep 011..111: expect `illegal_ir` = 1 for each.
  - LB is legal.
  - Load `funct3` 011, 110, 111: expect `illegal_ir` = 1.
- CSRRW x2, 0x300, x1 (`ir` = 0x3000_9173): expect `csr_addr` = 0x300, `wr_csr_n` = 0, `wr_reg_n` = 0, `illegal_ir` = 0. Change `funct3` to 100, expect `wr_csr_n` = 0 and `illegal_ir` = 1.
- ECALL (`ir` = 0x0000_0073): expect `wr_csr_n` = 1, `wr_reg_n` = 1, `illegal_ir` = 1.
- JALR with `funct3` = 001: expect `illegal_ir` = 1 and `wr_reg_n` = 0.
